// File: rtl/clint_multi.sv
// rtl/clint_multi.sv - multi-hart core-local interruptor (mtime, mtimecmp, msip) on a single-beat AXI4 slave
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   axi_ar* / axi_r*        read address / read data channels (arlen must be 0)
//   axi_aw* / axi_w* / axi_b*  write address / write data / write response channels (awlen must be 0)
//   mtip[h], msip[h]        level timer and software interrupts to hart h
//
// Map (offset from BASE_ADDR): msip[h] 0x0000+4h, mtimecmp[h] 0x4000+8h, mtime 0xBFF8.
module clint_multi #(
  parameter int          NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           axi_arid,
  input  logic [7:0]           axi_arlen,
  input  logic [2:0]           axi_arsize,
  input  logic [1:0]           axi_arburst,
  input  logic [31:0]          axi_araddr,
  input  logic                 axi_arvalid,
  output logic                 axi_arready,
  output logic [63:0]          axi_rdata,
  output logic [1:0]           axi_rresp,
  output logic [3:0]           axi_rid,
  output logic                 axi_rlast,
  output logic                 axi_rvalid,
  input  logic                 axi_rready,
  input  logic [3:0]           axi_awid,
  input  logic [7:0]           axi_awlen,
  input  logic [2:0]           axi_awsize,
  input  logic [1:0]           axi_awburst,
  input  logic [31:0]          axi_awaddr,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [63:0]          axi_wdata,
  input  logic [7:0]           axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [3:0]           axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip
);

  localparam logic [1:0] K_MSIP  = 2'd0;
  localparam logic [1:0] K_CMP   = 2'd1;
  localparam logic [1:0] K_MTIME = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic        ok;
    logic [1:0]  kind;
    logic [11:0] hart;
  } dec_t;

  typedef enum logic {R_IDLE, R_RESP} rd_state_t;
  typedef enum logic {W_COLLECT, W_RESP} wr_state_t;

  // Full address decode; anything not landing on an implemented register is an error.
  function automatic dec_t decode(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size);
    dec_t d;
    d.ok   = 1'b0;
    d.kind = K_MSIP;
    d.hart = '0;
    if (a[31:16] == BASE_ADDR[31:16] && len == 8'd0 && size <= 3'd3) begin
      if (a[15:14] == 2'b00) begin
        d.kind = K_MSIP;
        d.hart = a[13:2];
        d.ok   = (int'(a[13:2]) < NUM_HARTS);
      end else if (a[15:14] == 2'b01) begin
        d.kind = K_CMP;
        d.hart = {1'b0, a[13:3]};
        d.ok   = (int'(a[13:3]) < NUM_HARTS);
      end else if (a[15:3] == 13'h17FF) begin
        d.kind = K_MTIME;
        d.ok   = 1'b1;
      end
    end
    return d;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  logic [63:0] mtime, mtime_nxt;
  logic [15:0] presc;
  logic [63:0] mtimecmp [NUM_HARTS];
  logic [63:0] cmp_nxt  [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_nxt, mtip_nxt;

  rd_state_t   rd_state;
  wr_state_t   wr_state;
  logic        aw_full, w_full;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [3:0]  aw_id;
  logic [63:0] w_data;
  logic [7:0]  w_strb;

  dec_t        rd_dec, wr_dec;
  logic [63:0] rd_val;
  logic        commit, wr_en, tick;

  logic unused_inputs;
  assign unused_inputs = ^{axi_arburst, axi_awburst, axi_wlast};

  assign tick   = (presc == 16'(TICK_DIV - 1));
  assign commit = (wr_state == W_COLLECT) && aw_full && w_full;
  assign wr_dec = decode(aw_addr, aw_len, aw_size);
  assign wr_en  = commit && wr_dec.ok;

  // Read data comes from current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_dec = decode(axi_araddr, axi_arlen, axi_arsize);
    rd_val = '0;
    if (rd_dec.ok) begin
      case (rd_dec.kind)
        K_MSIP: begin
          for (int i = 0; i < NUM_HARTS; i++)
            if (int'(rd_dec.hart) == i) rd_val = {31'b0, msip[i], 31'b0, msip[i]};
        end
        K_CMP: begin
          for (int i = 0; i < NUM_HARTS; i++)
            if (int'(rd_dec.hart) == i) rd_val = mtimecmp[i];
        end
        default: rd_val = mtime;
      endcase
    end
  end

  // Next register state: bus write beats the tick; mtip compares post-update values.
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    msip_nxt  = msip;
    for (int i = 0; i < NUM_HARTS; i++) cmp_nxt[i] = mtimecmp[i];
    if (wr_en) begin
      case (wr_dec.kind)
        K_MSIP: begin
          for (int i = 0; i < NUM_HARTS; i++) begin
            if (int'(wr_dec.hart) == i) begin
              if (aw_addr[2]) begin
                if (w_strb[4]) msip_nxt[i] = w_data[32];
              end else begin
                if (w_strb[0]) msip_nxt[i] = w_data[0];
              end
            end
          end
        end
        K_CMP: begin
          for (int i = 0; i < NUM_HARTS; i++)
            if (int'(wr_dec.hart) == i) cmp_nxt[i] = merge(mtimecmp[i], w_data, w_strb);
        end
        default: mtime_nxt = merge(mtime, w_data, w_strb);
      endcase
    end
    for (int i = 0; i < NUM_HARTS; i++) mtip_nxt[i] = (mtime_nxt >= cmp_nxt[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime <= '0;
      presc <= '0;
      for (int i = 0; i < NUM_HARTS; i++) mtimecmp[i] <= '1;
      msip  <= '0;
      mtip  <= '0;
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      mtime <= mtime_nxt;
      for (int i = 0; i < NUM_HARTS; i++) mtimecmp[i] <= cmp_nxt[i];
      msip  <= msip_nxt;
      mtip  <= mtip_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state    <= R_IDLE;
      axi_arready <= 1'b1;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
      axi_rid     <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (axi_arvalid && axi_arready) begin
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b1;
            axi_rlast   <= 1'b1;
            axi_rid     <= axi_arid;
            axi_rdata   <= rd_val;
            axi_rresp   <= rd_dec.ok ? RESP_OKAY : RESP_SLVERR;
            rd_state    <= R_RESP;
          end
        end
        default: begin
          if (axi_rvalid && axi_rready) begin
            axi_rvalid  <= 1'b0;
            axi_rlast   <= 1'b0;
            axi_arready <= 1'b1;
            rd_state    <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state    <= W_COLLECT;
      axi_awready <= 1'b1;
      axi_wready  <= 1'b1;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      axi_bid     <= '0;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      aw_addr     <= '0;
      aw_len      <= '0;
      aw_size     <= '0;
      aw_id       <= '0;
      w_data      <= '0;
      w_strb      <= '0;
    end else begin
      case (wr_state)
        W_COLLECT: begin
          if (axi_awvalid && axi_awready) begin
            aw_addr     <= axi_awaddr;
            aw_len      <= axi_awlen;
            aw_size     <= axi_awsize;
            aw_id       <= axi_awid;
            aw_full     <= 1'b1;
            axi_awready <= 1'b0;
          end
          if (axi_wvalid && axi_wready) begin
            w_data     <= axi_wdata;
            w_strb     <= axi_wstrb;
            w_full     <= 1'b1;
            axi_wready <= 1'b0;
          end
          if (commit) begin
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            axi_bvalid <= 1'b1;
            axi_bid    <= aw_id;
            axi_bresp  <= wr_dec.ok ? RESP_OKAY : RESP_SLVERR;
            wr_state   <= W_RESP;
          end
        end
        default: begin
          if (axi_bvalid && axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
            wr_state    <= W_COLLECT;
          end
        end
      endcase
    end
  end

endmodule
